// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-write path.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    GAP,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    W_SEC,
    W_MIN,
    W_HOUR
  } wsel_t;

  localparam logic [7:0] RTC_ADDR_SEC  = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR = 8'h23;

  localparam int unsigned HOUR_12H_BIT = 6;
  localparam int unsigned HOUR_PM_BIT  = 5;

  function automatic logic bcd_byte_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // 12h mode keeps only the 5-bit BCD hour (01..12) and adds the mode/PM flags.
  function automatic logic [7:0] hour_reg(input logic [7:0] hc, input logic pm,
                                          input logic fmt);
    logic [7:0] r;
    r = '0;
    if (fmt) begin
      r[HOUR_12H_BIT] = 1'b1;
      r[HOUR_PM_BIT]  = pm;
      r[4:0]          = hc[4:0];
    end else begin
      r[5:0] = hc[5:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_check.sv
// Combinational range check of a packed-BCD time for 12h or 24h mode.
module bcd_time_check
  import rtc_pkg::*;
(
  input  logic [7:0] hc,
  input  logic [7:0] mc,
  input  logic [7:0] sc,
  input  logic       format,
  output logic       ok
);

  logic digits_ok;
  logic ms_ok;
  logic hour_ok;

  always_comb begin
    digits_ok = bcd_byte_ok(hc) && bcd_byte_ok(mc) && bcd_byte_ok(sc);
    ms_ok     = (sc <= 8'h59) && (mc <= 8'h59);
    hour_ok   = format ? ((hc >= 8'h01) && (hc <= 8'h12)) : (hc <= 8'h23);
    ok        = digits_ok && ms_ok && hour_ok;
  end

endmodule

// File: rtl/rtc_time_writer.sv
// Validates a committed BCD time and writes seconds, minutes, hours to the RTC
// over a req/ack bus, reporting done or err.
module rtc_time_writer
  import rtc_pkg::*;
#(
  parameter logic [7:0]  ADDR_SEC    = RTC_ADDR_SEC,
  parameter logic [7:0]  ADDR_MIN    = RTC_ADDR_MIN,
  parameter logic [7:0]  ADDR_HOUR   = RTC_ADDR_HOUR,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit,
  input  logic [7:0] HC,
  input  logic [7:0] MC,
  input  logic [7:0] SC,
  input  logic       AmPm,
  input  logic       format,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state_q, state_d;
  wsel_t         idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit_q;
  logic          start;
  logic          timeout;
  logic          time_ok;

  logic [7:0] hc_q, mc_q, sc_q;
  logic       ampm_q, fmt_q;

  logic       wr_req_d, busy_d, done_d, err_d;
  logic [7:0] wr_addr_d, wr_data_d;

  // busy also covers the done/err pulse cycle, so a commit edge there is dropped
  assign start   = commit && !commit_q && !busy;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

  bcd_time_check u_check (
    .hc     (hc_q),
    .mc     (mc_q),
    .sc     (sc_q),
    .format (fmt_q),
    .ok     (time_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q   <= '0;
      mc_q   <= '0;
      sc_q   <= '0;
      ampm_q <= 1'b0;
      fmt_q  <= 1'b0;
    end else if (state_q == IDLE && start) begin
      hc_q   <= HC;
      mc_q   <= MC;
      sc_q   <= SC;
      ampm_q <= AmPm;
      fmt_q  <= format;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= W_SEC;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      commit_q <= commit;
      wr_req   <= wr_req_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) state_d = CHECK;
      CHECK: begin
        idx_d   = W_SEC;
        cnt_d   = '0;
        state_d = time_ok ? REQ : IDLE;
      end
      REQ: begin
        if (wr_ack) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        case (idx_q)
          W_SEC: begin
            idx_d   = W_MIN;
            state_d = REQ;
          end
          W_MIN: begin
            idx_d   = W_HOUR;
            state_d = REQ;
          end
          default: state_d = FIN;
        endcase
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each REQ entry presents
  // a stable address/data pair for the whole request.
  always_comb begin
    wr_req_d  = (state_d == REQ);
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (state_d == REQ && state_q != REQ) begin
      case (idx_d)
        W_SEC: begin
          wr_addr_d = ADDR_SEC;
          wr_data_d = sc_q;
        end
        W_MIN: begin
          wr_addr_d = ADDR_MIN;
          wr_data_d = mc_q;
        end
        default: begin
          wr_addr_d = ADDR_HOUR;
          wr_data_d = hour_reg(hc_q, ampm_q, fmt_q);
        end
      endcase
    end
    err_d  = ((state_q == CHECK) && !time_ok) ||
             ((state_q == REQ) && !wr_ack && timeout);
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE) || err_d;
  end

endmodule

// File: tb/tb_rtc_time_writer.sv
// Scoreboard bench for rtc_time_writer: directed commits, monitor checks writes and done/err.
module tb_rtc_time_writer;

  logic       clk;
  logic       reset;
  logic       commit;
  logic [7:0] HC, MC, SC;
  logic       AmPm, format;
  logic       wr_ack;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_wr[$];
  byte         q_ev[$];

  int   req_rises  = 0;
  int   req_hi_cnt = 0;
  int   busy_cnt   = 0;
  logic req_prev   = 1'b0;

  logic ack_en    = 1'b1;
  int   ack_delay = 1;
  int   req_cnt   = 0;

  rtc_time_writer #(.TIMEOUT_CYC(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .commit  (commit),
    .HC      (HC),
    .MC      (MC),
    .SC      (SC),
    .AmPm    (AmPm),
    .format  (format),
    .wr_ack  (wr_ack),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or pulse.
  initial begin
    logic [15:0] e;
    byte         ev;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wr_req && !req_prev) begin
          req_rises++;
          if (q_wr.size() == 0) chk("unexpected_write", {wr_addr, wr_data}, 16'hffff);
          else begin
            e = q_wr.pop_front();
            chk("write_addr_data", {wr_addr, wr_data}, e);
          end
        end
        if (wr_req) req_hi_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          if (q_ev.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            ev = q_ev.pop_front();
            chk("event_done", "D", ev);
          end
        end
        if (err) begin
          if (q_ev.size() == 0) chk("unexpected_err", 1, 0);
          else begin
            ev = q_ev.pop_front();
            chk("event_err", "E", ev);
          end
        end
      end
      req_prev = wr_req;
    end
  end

  // Bus responder: acks once the request has been up for ack_delay+1 sampled cycles.
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req) begin
        req_cnt++;
        wr_ack = ack_en && (req_cnt == ack_delay + 1);
      end else begin
        req_cnt = 0;
        wr_ack  = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    q_wr.push_back({a, d});
  endtask

  task automatic apply(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                       input logic pm, input logic fm);
    @(negedge clk);
    HC = h; MC = m; SC = s; AmPm = pm; format = fm;
    commit = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, busy, 0);
    @(negedge clk);
    commit = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_counts();
    req_rises = 0; req_hi_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    int lat, n;
    reset = 1'b1; commit = 1'b0;
    HC = '0; MC = '0; SC = '0; AmPm = 1'b0; format = 1'b0;
    #12;
    chk("reset_outputs", {wr_req, wr_addr, wr_data, busy, done, err}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 24h valid with latency from the commit-sampling edge to done
    ack_en = 1'b1; ack_delay = 1; clear_counts();
    push_wr(8'h21, 8'h58); push_wr(8'h22, 8'h59); push_wr(8'h23, 8'h23); q_ev.push_back("D");
    apply(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i - 1;
        break;
      end
    end
    chk("done_latency", lat, 10);
    wait_idle("idle_24h");
    chk("writes_24h", req_rises, 3);

    // 12h PM and AM
    clear_counts();
    push_wr(8'h21, 8'h00); push_wr(8'h22, 8'h30); push_wr(8'h23, 8'h67); q_ev.push_back("D");
    apply(8'h07, 8'h30, 8'h00, 1'b1, 1'b1);
    wait_idle("idle_12h_pm");
    push_wr(8'h21, 8'h00); push_wr(8'h22, 8'h30); push_wr(8'h23, 8'h47); q_ev.push_back("D");
    apply(8'h07, 8'h30, 8'h00, 1'b0, 1'b1);
    wait_idle("idle_12h_am");
    chk("writes_12h", req_rises, 6);

    // Invalid inputs: err pulse, no request, busy exactly 2 cycles
    clear_counts(); q_ev.push_back("E");
    apply(8'h24, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_idle("idle_bad_hc24");
    chk("bad_hc24_busy", busy_cnt, 2);
    chk("bad_hc24_req", req_rises, 0);

    clear_counts(); q_ev.push_back("E");
    apply(8'h00, 8'h10, 8'h10, 1'b0, 1'b1);
    wait_idle("idle_bad_hc00");
    chk("bad_hc00_busy", busy_cnt, 2);
    chk("bad_hc00_req", req_rises, 0);

    clear_counts(); q_ev.push_back("E");
    apply(8'h12, 8'h00, 8'h5A, 1'b0, 1'b0);
    wait_idle("idle_bad_sc");
    chk("bad_sc_busy", busy_cnt, 2);
    chk("bad_sc_req", req_rises, 0);

    // Ack timeout: request held 8 cycles, then err, later writes skipped
    clear_counts(); ack_en = 1'b0;
    push_wr(8'h21, 8'h30); q_ev.push_back("E");
    apply(8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    wait_idle("idle_timeout");
    chk("timeout_req_cycles", req_hi_cnt, 8);
    chk("timeout_writes", req_rises, 1);
    ack_en = 1'b1;

    // Commit edge while busy is ignored; input change after commit has no effect
    clear_counts(); ack_delay = 3;
    push_wr(8'h21, 8'h15); push_wr(8'h22, 8'h45); push_wr(8'h23, 8'h51); q_ev.push_back("D");
    apply(8'h11, 8'h45, 8'h15, 1'b0, 1'b1);
    @(negedge clk);
    HC = 8'h05; MC = 8'h01; SC = 8'h02; AmPm = 1'b1;
    n = 0;
    while (req_rises < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    commit = 1'b0;
    @(negedge clk);
    commit = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    // commit stays high past completion: no retrigger
    repeat (20) @(negedge clk);
    chk("busy_commit_writes", req_rises, 3);
    chk("held_commit_idle", busy, 0);
    commit = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset during the minutes request, then a clean sequence
    clear_counts();
    push_wr(8'h21, 8'h01); push_wr(8'h22, 8'h05); push_wr(8'h23, 8'h09); q_ev.push_back("D");
    apply(8'h09, 8'h05, 8'h01, 1'b0, 1'b0);
    n = 0;
    while (req_rises < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_min_write", req_rises, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_wr_req", wr_req, 0);
    chk("areset_busy", busy, 0);
    q_wr.delete(); q_ev.delete();
    commit = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_counts(); ack_delay = 1;
    push_wr(8'h21, 8'h59); push_wr(8'h22, 8'h00); push_wr(8'h23, 8'h19); q_ev.push_back("D");
    apply(8'h19, 8'h00, 8'h59, 1'b0, 1'b0);
    wait_idle("idle_after_reset");
    chk("writes_after_reset", req_rises, 3);

    chk("wr_queue_empty", q_wr.size(), 0);
    chk("ev_queue_empty", q_ev.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
